// File: rtl/uart_matrix_parser.sv
// Parses "m n e0 .. e(m*n-1)" ASCII decimal text from the UART and writes the elements row-major to storage.
// Optional inter-byte idle timeout is compiled in with `define PARSE_TIMEOUT_EN.
module uart_matrix_parser #(
    parameter int MAX_DIM        = 5,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [31:0]       o_m,
    output logic [31:0]       o_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_err_code
);

    localparam int EXT_W  = DATA_W + 4;
    localparam int TOT_RQ = $clog2(MAX_DIM * MAX_DIM + 1);
    localparam int TOT_W  = (TOT_RQ > 6) ? TOT_RQ : 6;

    localparam logic [EXT_W-1:0]  TEN     = EXT_W'(10);
    localparam logic [DATA_W-1:0] DIM_MAX = DATA_W'(MAX_DIM);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_CHAR  = 3'd1;
    localparam logic [2:0] ERR_RANGE = 3'd2;
    localparam logic [2:0] ERR_OVF   = 3'd3;
    localparam logic [2:0] ERR_TMO   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_M, S_GET_N, S_GET_ELEM, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                seen_q, seen_d;
    logic [TOT_W-1:0]    idx_q, idx_d;
    logic [TOT_W-1:0]    total_q, total_d;
    logic [31:0]         m_q, m_d;
    logic [31:0]         n_q, n_d;
    logic [2:0]          code_q, code_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, done_q, err_q;

    logic [EXT_W-1:0]    acc_next;
    logic [TOT_W-1:0]    idx_inc;
    logic                is_digit, is_sep, in_range, overflow, active, timeout_hit;

    assign active   = (state_q == S_GET_M) || (state_q == S_GET_N) || (state_q == S_GET_ELEM);
    assign is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
    assign is_sep   = (i_rx_data == 8'h20) || (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    assign acc_next = EXT_W'(acc_q) * TEN + EXT_W'(i_rx_data[3:0]);
    assign overflow = (acc_next[EXT_W-1:DATA_W] != '0);
    assign in_range = (acc_q != '0) && (acc_q <= DIM_MAX);
    assign idx_inc  = idx_q + TOT_W'(1);

`ifdef PARSE_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d    = '0;
        timeout_hit = 1'b0;
        if (active && i_start && !i_rx_valid) begin
            to_cnt_d    = to_cnt_q + 32'd1;
            timeout_hit = (to_cnt_d == 32'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    // Always false; the parser waits indefinitely for the next byte.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        acc_d     = acc_q;
        seen_d    = seen_q;
        idx_d     = idx_q;
        total_d   = total_q;
        m_d       = m_q;
        n_d       = n_q;
        code_d    = code_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_GET_M;
                    base_d  = i_base_addr;
                    acc_d   = '0;
                    seen_d  = 1'b0;
                    idx_d   = '0;
                    code_d  = ERR_NONE;
                end
            end

            S_GET_M, S_GET_N, S_GET_ELEM: begin
                if (!i_start) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                    code_d  = ERR_TMO;
                end else if (i_rx_valid) begin
                    if (is_digit) begin
                        if (overflow) begin
                            state_d = S_ERR;
                            code_d  = ERR_OVF;
                        end else begin
                            acc_d  = acc_next[DATA_W-1:0];
                            seen_d = 1'b1;
                        end
                    end else if (is_sep) begin
                        if (seen_q) begin
                            acc_d  = '0;
                            seen_d = 1'b0;
                            if (state_q == S_GET_ELEM) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = base_q + ADDR_W'(idx_q);
                                wr_data_d = acc_q;
                                idx_d     = idx_inc;
                                if (idx_inc == total_q) state_d = S_DONE;
                            end else if (!in_range) begin
                                state_d = S_ERR;
                                code_d  = ERR_RANGE;
                            end else if (state_q == S_GET_M) begin
                                m_d     = 32'(acc_q);
                                state_d = S_GET_N;
                            end else begin
                                n_d     = 32'(acc_q);
                                total_d = TOT_W'(m_q) * TOT_W'(acc_q);
                                state_d = S_GET_ELEM;
                            end
                        end
                    end else begin
                        state_d = S_ERR;
                        code_d  = ERR_CHAR;
                    end
                end
            end

            S_DONE, S_ERR: begin
                if (!i_start) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            acc_q     <= '0;
            seen_q    <= 1'b0;
            idx_q     <= '0;
            total_q   <= '0;
            m_q       <= '0;
            n_q       <= '0;
            code_q    <= ERR_NONE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            seen_q    <= seen_d;
            idx_q     <= idx_d;
            total_q   <= total_d;
            m_q       <= m_d;
            n_q       <= n_d;
            code_q    <= code_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= (state_d == S_GET_M) || (state_d == S_GET_N) || (state_d == S_GET_ELEM);
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERR);
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_m        = m_q;
    assign o_n        = n_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;

endmodule

// File: tb/tb_uart_matrix_parser.sv
// Directed bench for uart_matrix_parser: expected writes go into a scoreboard queue, observed writes are collected by a monitor.
module tb_uart_matrix_parser;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic              i_rx_valid = 1'b0;
    logic [7:0]        i_rx_data = '0;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic [31:0]       o_m, o_n;
    logic              o_busy, o_done, o_err;
    logic [2:0]        o_err_code;

    always #5 clk = ~clk;

    uart_matrix_parser #(
        .MAX_DIM(5), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_m(o_m), .o_n(o_n), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_err_code(o_err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rd_ptr = 0;
    logic last_wr = 1'b0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] obs_q[$];

    always @(negedge clk)
        if (rst_n && o_wr_en) obs_q.push_back({o_wr_addr, o_wr_data});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic expect_writes(input string tag);
        logic [ADDR_W+DATA_W-1:0] e;
        check({tag, "_count"}, 64'(obs_q.size() - rd_ptr), 64'(exp_q.size()));
        while (exp_q.size() > 0 && rd_ptr < obs_q.size()) begin
            e = exp_q.pop_front();
            check({tag, "_wr"}, 64'(obs_q[rd_ptr]), 64'(e));
            rd_ptr++;
        end
        exp_q.delete();
        rd_ptr = obs_q.size();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge clk);
        i_rx_valid = 1'b0;
        last_wr    = o_wr_en;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic start_req(input logic [ADDR_W-1:0] base);
        @(negedge clk);
        i_base_addr = base;
        i_start     = 1'b1;
        @(negedge clk);
    endtask

    task automatic stop_req();
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_wr_en", 64'(o_wr_en), 64'd0);
        check("rst_m", 64'(o_m), 64'd0);
        check("rst_code", 64'(o_err_code), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2x3 matrix at base 0x10
        start_req(8'h10);
        check("m23_busy", 64'(o_busy), 64'd1);
        for (int i = 0; i < 6; i++) push_wr(8'h10 + 8'(i), 32'(i + 1));
        send_str("2 3 1 2 3 4 5 6");
        check("m23_no_wr_on_digit", 64'(last_wr), 64'd0);
        send_byte(8'h0D);
        check("m23_wr_latency", 64'(last_wr), 64'd1);
        send_byte(8'h0A);
        check("m23_done", 64'(o_done), 64'd1);
        check("m23_busy_low", 64'(o_busy), 64'd0);
        check("m23_m", 64'(o_m), 64'd2);
        check("m23_n", 64'(o_n), 64'd3);
        expect_writes("m23");
        stop_req();
        check("m23_done_clear", 64'(o_done), 64'd0);

        // extra separators, max value
        start_req(8'h20);
        push_wr(8'h20, 32'hFFFF_FFFF);
        send_str("1  1\r\n\r\n4294967295 ");
        check("max_done", 64'(o_done), 64'd1);
        expect_writes("max");
        stop_req();

        // overflow
        start_req(8'h30);
        send_str("1 1 4294967296 ");
        check("ovf_err", 64'(o_err), 64'd1);
        check("ovf_code", 64'(o_err_code), 64'd3);
        check("ovf_done", 64'(o_done), 64'd0);
        expect_writes("ovf");
        stop_req();
        check("ovf_err_clear", 64'(o_err), 64'd0);
        check("ovf_idle", 64'(o_busy), 64'd0);

        // dimension range and illegal character
        start_req(8'h00);
        send_str("6 ");
        check("rng6_err", 64'(o_err), 64'd1);
        check("rng6_code", 64'(o_err_code), 64'd2);
        send_str("2 ");
        stop_req();
        start_req(8'h00);
        check("restart_code_clear", 64'(o_err_code), 64'd0);
        send_str("0 ");
        check("rng0_code", 64'(o_err_code), 64'd2);
        stop_req();
        start_req(8'h00);
        send_str("2 x");
        check("char_err", 64'(o_err), 64'd1);
        check("char_code", 64'(o_err_code), 64'd1);
        expect_writes("errs");
        stop_req();

        // address wrap
        start_req(8'hFE);
        push_wr(8'hFE, 32'd7);
        push_wr(8'hFF, 32'd8);
        push_wr(8'h00, 32'd9);
        send_str("1 3 7 8 9 ");
        check("wrap_done", 64'(o_done), 64'd1);
        expect_writes("wrap");
        stop_req();

        // abort after first element
        start_req(8'hFE);
        push_wr(8'hFE, 32'd7);
        send_str("1 3 7 ");
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(o_busy), 64'd0);
        check("abort_done", 64'(o_done), 64'd0);
        check("abort_err", 64'(o_err), 64'd0);
        send_str("8 9 ");
        check("abort_done_late", 64'(o_done), 64'd0);
        expect_writes("abort");

        // reset while a write strobe is being registered
        start_req(8'h40);
        send_str("1 1 5");
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h20;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_wr_en", 64'(o_wr_en), 64'd0);
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(o_busy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_writes("rst_mid");

        // inter-byte idle
        start_req(8'h00);
        send_str("2 ");
        repeat (1100) @(negedge clk);
`ifdef PARSE_TIMEOUT_EN
        check("tmo_err", 64'(o_err), 64'd1);
        check("tmo_code", 64'(o_err_code), 64'd4);
`else
        check("idle_busy", 64'(o_busy), 64'd1);
        check("idle_err", 64'(o_err), 64'd0);
`endif
        stop_req();
        check("final_idle", 64'(o_busy | o_done | o_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
